// File: rtl/alu_exec_latch.sv
// Execute-stage output register behind the 64-bit ALU: valid/ready result
// latch, architectural NZCV register and registered branch decision.
module alu_exec_latch #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_negative,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  input  logic             alu_carry_out,
  input  logic             set_flags,
  input  logic             is_bcond,
  input  logic             is_cbz,
  input  logic             is_cbnz,
  input  logic [3:0]       cond,
  input  logic [4:0]       rd,
  input  logic             reg_write,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [4:0]       out_rd,
  output logic             out_reg_write,
  output logic             branch_taken,
  output logic [3:0]       flags_q
);

  logic             out_valid_q,     out_valid_d;
  logic [WIDTH-1:0] out_result_q,    out_result_d;
  logic [4:0]       out_rd_q,        out_rd_d;
  logic             out_reg_write_q, out_reg_write_d;
  logic             branch_taken_q,  branch_taken_d;
  logic [3:0]       flags_d;

  logic accept;
  logic cond_base;
  logic cond_pass;
  logic decision;
  logic f_n, f_z, f_c, f_v;

  assign in_ready = ~out_valid_q | out_ready;
  assign accept   = in_valid & in_ready & ~flush;
  assign {f_n, f_z, f_c, f_v} = flags_q;

  // B.cond evaluation against the pre-update architectural flags; odd
  // codes invert the even base condition, except the 111x always-taken pair.
  always_comb begin
    cond_base = 1'b0;
    case (cond[3:1])
      3'b000:  cond_base = f_z;
      3'b001:  cond_base = f_c;
      3'b010:  cond_base = f_n;
      3'b011:  cond_base = f_v;
      3'b100:  cond_base = f_c & ~f_z;
      3'b101:  cond_base = (f_n == f_v);
      3'b110:  cond_base = ~f_z & (f_n == f_v);
      default: cond_base = 1'b1;
    endcase
    cond_pass = (cond[3:1] == 3'b111) ? 1'b1 : (cond_base ^ cond[0]);
  end

  // Branch decision with priority B.cond > CBZ > CBNZ.
  always_comb begin
    decision = 1'b0;
    if (is_bcond)     decision = cond_pass;
    else if (is_cbz)  decision = alu_zero;
    else if (is_cbnz) decision = ~alu_zero;
  end

  // Next-state for the pipeline register and flags: flush beats accept,
  // accept beats drain, otherwise hold.
  always_comb begin
    out_valid_d     = out_valid_q;
    out_result_d    = out_result_q;
    out_rd_d        = out_rd_q;
    out_reg_write_d = out_reg_write_q;
    branch_taken_d  = branch_taken_q;
    flags_d         = flags_q;
    if (flush) begin
      out_valid_d     = 1'b0;
      out_reg_write_d = 1'b0;
      branch_taken_d  = 1'b0;
    end else if (accept) begin
      out_valid_d     = 1'b1;
      out_result_d    = alu_result;
      out_rd_d        = rd;
      out_reg_write_d = reg_write;
      branch_taken_d  = decision;
      if (set_flags) begin
        flags_d = {alu_negative, alu_zero, alu_carry_out, alu_overflow};
      end
    end else if (out_valid_q & out_ready) begin
      out_valid_d     = 1'b0;
      out_reg_write_d = 1'b0;
      branch_taken_d  = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q     <= 1'b0;
      out_result_q    <= '0;
      out_rd_q        <= '0;
      out_reg_write_q <= 1'b0;
      branch_taken_q  <= 1'b0;
      flags_q         <= '0;
    end else begin
      out_valid_q     <= out_valid_d;
      out_result_q    <= out_result_d;
      out_rd_q        <= out_rd_d;
      out_reg_write_q <= out_reg_write_d;
      branch_taken_q  <= branch_taken_d;
      flags_q         <= flags_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_result    = out_result_q;
  assign out_rd        = out_rd_q;
  assign out_reg_write = out_reg_write_q & out_valid_q;
  assign branch_taken  = branch_taken_q & out_valid_q;

endmodule

// File: tb/tb_alu_exec_latch.sv
// Directed bench for alu_exec_latch: vector table plus stall/flush/reset sequences.
module tb_alu_exec_latch;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] alu_result;
  logic        alu_negative, alu_zero, alu_overflow, alu_carry_out;
  logic        set_flags, is_bcond, is_cbz, is_cbnz;
  logic [3:0]  cond;
  logic [4:0]  rd;
  logic        reg_write;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;
  logic [4:0]  out_rd;
  logic        out_reg_write;
  logic        branch_taken;
  logic [3:0]  flags_q;

  int n_tests = 0;
  int n_fail  = 0;

  alu_exec_latch #(.WIDTH(64)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .alu_negative(alu_negative), .alu_zero(alu_zero),
    .alu_overflow(alu_overflow), .alu_carry_out(alu_carry_out),
    .set_flags(set_flags), .is_bcond(is_bcond), .is_cbz(is_cbz), .is_cbnz(is_cbnz),
    .cond(cond), .rd(rd), .reg_write(reg_write), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_reg_write(out_reg_write), .branch_taken(branch_taken),
    .flags_q(flags_q)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        iv;
    logic [63:0] res;
    logic        n, z, c, v;
    logic        sf, bc, cz, cnz;
    logic [3:0]  cnd;
    logic [4:0]  rdi;
    logic        rw;
    logic        fl;
    logic        ev;
    logic [63:0] eres;
    logic [4:0]  erd;
    logic        erw;
    logic        ebr;
    logic [3:0]  efl;
  } vec_t;

  vec_t vecs[23];

  function automatic vec_t mkv(
    input logic iv, input logic [63:0] res,
    input logic n, input logic z, input logic c, input logic v,
    input logic sf, input logic bc, input logic cz, input logic cnz,
    input logic [3:0] cnd, input logic [4:0] rdi, input logic rw, input logic fl,
    input logic ev, input logic [63:0] eres, input logic [4:0] erd,
    input logic erw, input logic ebr, input logic [3:0] efl);
    vec_t t;
    t.iv = iv; t.res = res; t.n = n; t.z = z; t.c = c; t.v = v;
    t.sf = sf; t.bc = bc; t.cz = cz; t.cnz = cnz; t.cnd = cnd;
    t.rdi = rdi; t.rw = rw; t.fl = fl; t.ev = ev; t.eres = eres;
    t.erd = erd; t.erw = erw; t.ebr = ebr; t.efl = efl;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_in(
    input logic iv, input logic [63:0] res,
    input logic n, input logic z, input logic c, input logic v,
    input logic sf, input logic bc, input logic cz, input logic cnz,
    input logic [3:0] cnd, input logic [4:0] rdi, input logic rw);
    in_valid = iv; alu_result = res;
    alu_negative = n; alu_zero = z; alu_carry_out = c; alu_overflow = v;
    set_flags = sf; is_bcond = bc; is_cbz = cz; is_cbnz = cnz;
    cond = cnd; rd = rdi; reg_write = rw;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic ev, input logic erw,
                           input logic ebr, input logic [3:0] efl, input logic eir);
    chk({tag, ".out_valid"},     {63'd0, out_valid},     {63'd0, ev});
    chk({tag, ".out_reg_write"}, {63'd0, out_reg_write}, {63'd0, erw});
    chk({tag, ".branch_taken"},  {63'd0, branch_taken},  {63'd0, ebr});
    chk({tag, ".flags_q"},       {60'd0, flags_q},       {60'd0, efl});
    chk({tag, ".in_ready"},      {63'd0, in_ready},      {63'd0, eir});
  endtask

  initial begin
    // iv res n z c v sf bc cz cnz cond rd rw fl | ev eres erd erw ebr eflags
    vecs[0]  = mkv(1, 64'h2A, 0,0,0,0, 0,0,0,0, 4'b0000, 5'd5, 1, 0,  1, 64'h2A, 5'd5, 1, 0, 4'b0000);
    vecs[1]  = mkv(1, 64'h0,  0,1,1,0, 1,0,0,0, 4'b0000, 5'd3, 1, 0,  1, 64'h0,  5'd3, 1, 0, 4'b0110);
    vecs[2]  = mkv(1, 64'h100,0,0,0,0, 0,1,0,0, 4'b0000, 5'd0, 0, 0,  1, 64'h100,5'd0, 0, 1, 4'b0110);
    vecs[3]  = mkv(1, 64'h104,0,0,0,0, 0,1,0,0, 4'b0001, 5'd0, 0, 0,  1, 64'h104,5'd0, 0, 0, 4'b0110);
    vecs[4]  = mkv(1, 64'hFFFF_FFFF_FFFF_FFF0, 1,0,0,0, 1,0,0,0, 4'b0000, 5'd2, 1, 0,
                   1, 64'hFFFF_FFFF_FFFF_FFF0, 5'd2, 1, 0, 4'b1000);
    vecs[5]  = mkv(1, 64'h200,0,0,0,0, 0,1,0,0, 4'b1011, 5'd0, 0, 0,  1, 64'h200,5'd0, 0, 1, 4'b1000);
    vecs[6]  = mkv(1, 64'h204,0,0,0,0, 0,1,0,0, 4'b1100, 5'd0, 0, 0,  1, 64'h204,5'd0, 0, 0, 4'b1000);
    vecs[7]  = mkv(1, 64'h208,0,0,0,0, 0,1,0,0, 4'b1110, 5'd0, 0, 0,  1, 64'h208,5'd0, 0, 1, 4'b1000);
    vecs[8]  = mkv(1, 64'h20C,0,0,0,0, 0,1,0,0, 4'b1010, 5'd0, 0, 0,  1, 64'h20C,5'd0, 0, 0, 4'b1000);
    vecs[9]  = mkv(1, 64'h0,  0,1,0,0, 0,0,1,0, 4'b0000, 5'd7, 0, 0,  1, 64'h0,  5'd7, 0, 1, 4'b1000);
    vecs[10] = mkv(1, 64'h11, 0,1,0,0, 0,0,0,1, 4'b0000, 5'd8, 0, 0,  1, 64'h11, 5'd8, 0, 0, 4'b1000);
    vecs[11] = mkv(1, 64'h12, 0,0,0,0, 0,0,0,1, 4'b0000, 5'd8, 0, 0,  1, 64'h12, 5'd8, 0, 1, 4'b1000);
    vecs[12] = mkv(1, 64'h0,  0,1,0,0, 0,1,1,0, 4'b0000, 5'd1, 0, 0,  1, 64'h0,  5'd1, 0, 0, 4'b1000);
    vecs[13] = mkv(1, 64'h13, 0,0,0,0, 0,0,1,1, 4'b0000, 5'd1, 0, 0,  1, 64'h13, 5'd1, 0, 0, 4'b1000);
    vecs[14] = mkv(1, 64'h55, 0,1,0,1, 1,1,0,0, 4'b0110, 5'd12,1, 0,  1, 64'h55, 5'd12,1, 0, 4'b0101);
    vecs[15] = mkv(1, 64'h56, 0,0,0,0, 0,1,0,0, 4'b0110, 5'd0, 0, 0,  1, 64'h56, 5'd0, 0, 1, 4'b0101);
    vecs[16] = mkv(1, 64'h57, 0,0,0,0, 0,1,0,0, 4'b1000, 5'd0, 0, 0,  1, 64'h57, 5'd0, 0, 0, 4'b0101);
    vecs[17] = mkv(1, 64'h58, 0,0,0,0, 0,1,0,0, 4'b1001, 5'd0, 0, 0,  1, 64'h58, 5'd0, 0, 1, 4'b0101);
    vecs[18] = mkv(1, 64'h59, 0,0,0,0, 0,1,0,0, 4'b1101, 5'd0, 0, 0,  1, 64'h59, 5'd0, 0, 1, 4'b0101);
    vecs[19] = mkv(0, 64'h0,  0,0,0,0, 0,0,0,0, 4'b0000, 5'd0, 0, 0,  0, 64'h0,  5'd0, 0, 0, 4'b0101);
    vecs[20] = mkv(0, 64'h0,  0,0,0,0, 0,0,0,0, 4'b0000, 5'd0, 0, 0,  0, 64'h0,  5'd0, 0, 0, 4'b0101);
    vecs[21] = mkv(1, 64'h66, 1,0,1,0, 1,1,0,0, 4'b1110, 5'd9, 1, 1,  0, 64'h0,  5'd0, 0, 0, 4'b0101);
    vecs[22] = mkv(1, 64'h77, 0,0,0,0, 0,0,0,0, 4'b0000, 5'd31,1, 0,  1, 64'h77, 5'd31,1, 0, 4'b0101);

    set_in(0, 64'h0, 0,0,0,0, 0,0,0,0, 4'b0000, 5'd0, 0);
    flush = 0; out_ready = 1; reset = 1;
    step(); step();
    reset = 0;
    step();
    chk_state("reset", 0, 0, 0, 4'b0000, 1);
    chk("reset.out_result", out_result, 64'h0);
    chk("reset.out_rd", {59'd0, out_rd}, 64'h0);

    for (int i = 0; i < 23; i++) begin
      set_in(vecs[i].iv, vecs[i].res, vecs[i].n, vecs[i].z, vecs[i].c, vecs[i].v,
             vecs[i].sf, vecs[i].bc, vecs[i].cz, vecs[i].cnz, vecs[i].cnd,
             vecs[i].rdi, vecs[i].rw);
      flush = vecs[i].fl;
      step();
      chk_state($sformatf("vec%0d", i), vecs[i].ev, vecs[i].erw, vecs[i].ebr, vecs[i].efl, 1);
      if (vecs[i].ev) begin
        chk($sformatf("vec%0d.out_result", i), out_result, vecs[i].eres);
        chk($sformatf("vec%0d.out_rd", i), {59'd0, out_rd}, {59'd0, vecs[i].erd});
      end
    end
    flush = 0;

    // Stall: hold A for 3 cycles while B (flag-setting) waits at the input.
    set_in(1, 64'hAAAA_0000_0000_AAAA, 0,0,0,0, 0,1,0,0, 4'b1110, 5'd9, 1);
    step();
    chk_state("stallA", 1, 1, 1, 4'b0101, 1);
    set_in(1, 64'hBBBB_0000_0000_BBBB, 1,0,1,1, 1,0,1,0, 4'b0000, 5'd10, 1);
    out_ready = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_state($sformatf("stall%0d", k), 1, 1, 1, 4'b0101, 0);
      chk($sformatf("stall%0d.out_result", k), out_result, 64'hAAAA_0000_0000_AAAA);
      chk($sformatf("stall%0d.out_rd", k), {59'd0, out_rd}, 64'd9);
    end
    out_ready = 1;
    #1;
    chk("release.in_ready", {63'd0, in_ready}, 64'd1);
    step();
    chk_state("stallB", 1, 1, 0, 4'b1011, 1);
    chk("stallB.out_result", out_result, 64'hBBBB_0000_0000_BBBB);
    chk("stallB.out_rd", {59'd0, out_rd}, 64'd10);
    set_in(0, 64'h0, 0,0,0,0, 0,0,0,0, 4'b0000, 5'd0, 0);
    step();
    chk_state("drainB", 0, 0, 0, 4'b1011, 1);

    // Flush while stalled, incoming instruction tries to set flags.
    set_in(1, 64'hC0C0, 0,0,0,0, 0,0,0,0, 4'b0000, 5'd4, 1);
    step();
    chk_state("accC", 1, 1, 0, 4'b1011, 1);
    out_ready = 0;
    set_in(1, 64'hD0D0, 0,1,0,0, 1,0,1,0, 4'b0000, 5'd6, 1);
    step();
    chk_state("stallC", 1, 1, 0, 4'b1011, 0);
    flush = 1;
    step();
    chk_state("flushC", 0, 0, 0, 4'b1011, 1);
    flush = 0;
    out_ready = 1;

    // Reset mid-stream with a valid, flag-setting instruction held and offered.
    set_in(1, 64'hE, 0,1,1,0, 1,1,0,0, 4'b1110, 5'd6, 1);
    step();
    chk_state("accE", 1, 1, 1, 4'b0110, 1);
    out_ready = 0;
    reset = 1;
    set_in(1, 64'hF, 1,0,0,1, 1,1,0,0, 4'b1110, 5'd7, 1);
    step();
    chk_state("rstmid", 0, 0, 0, 4'b0000, 1);
    chk("rstmid.out_result", out_result, 64'h0);
    chk("rstmid.out_rd", {59'd0, out_rd}, 64'h0);
    reset = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_exec_latch.md
# alu_exec_latch

Execute-stage output register placed directly downstream of the 64-bit ALU. It captures the ALU result and its four status flags into a valid/ready pipeline register, and maintains the architectural NZCV condition register, updated only by flag-setting instructions. It evaluates conditional-branch (B.cond) and compare-and-branch (CBZ/CBNZ) decisions and presents them, registered, to the memory/branch stage.

## Interface
Parameters:
- WIDTH, 64, data width of the ALU result path.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  ALU outputs and instruction attributes this cycle are valid.
- in_ready  output  1  stage can accept; combinational: ~out_valid | out_ready.
- alu_result  input  WIDTH  ALU result bus.
- alu_negative, alu_zero, alu_overflow, alu_carry_out  input  1 each  ALU status flags.
- set_flags  input  1  instruction updates NZCV on acceptance.
- is_bcond  input  1  instruction is B.cond.
- is_cbz  input  1  instruction is CBZ.
- is_cbnz  input  1  instruction is CBNZ.
- cond  input  4  B.cond condition code.
- rd  input  5  destination register index.
- reg_write  input  1  instruction writes rd.
- flush  input  1  kill held and incoming instruction.
- out_valid  output  1  output register holds a valid instruction.
- out_ready  input  1  downstream accepts this cycle.
- out_result  output  WIDTH  registered alu_result.
- out_rd  output  5  registered rd.
- out_reg_write  output  1  registered reg_write, forced 0 when out_valid=0.
- branch_taken  output  1  registered branch decision, forced 0 when out_valid=0.
- flags_q  output  4  architectural {N,Z,C,V}.

## Operation
- Accept = in_valid & in_ready & ~flush. On accept, load out_result, out_rd, out_reg_write and branch_taken; set out_valid=1.
- Drain: out_valid & out_ready & ~accept -> out_valid=0.
- Stall: out_valid & ~out_ready -> all registered outputs hold, in_ready=0, flags_q holds.
- Flag update: on accept with set_flags=1, flags_q <= {alu_negative, alu_zero, alu_carry_out, alu_overflow}. Otherwise flags_q holds.
- Branch decision, evaluated at accept. Priority when more than one is set: is_bcond > is_cbz > is_cbnz. If none is set, the decision is 0.
  - is_bcond uses the flags_q value before this cycle's update.
  - is_cbz: taken = alu_zero. is_cbnz: taken = ~alu_zero.
- Condition codes (N,Z,C,V from flags_q):
  - 0000 EQ Z; 0001 NE ~Z.
  - 0010 HS C; 0011 LO ~C.
  - 0100 MI N; 0101 PL ~N.
  - 0110 VS V; 0111 VC ~V.
  - 1000 HI C&~Z; 1001 LS ~(C&~Z).
  - 1010 GE N==V; 1011 LT N!=V.
  - 1100 GT ~Z&(N==V); 1101 LE ~(~Z&(N==V)).
  - 1110 and 1111 always taken.
- Flush: next cycle out_valid=0 and out_reg_write=0. The incoming instruction is not accepted and its set_flags is ignored. Flush overrides stall.
- Reset overrides flush and accept. Reset mid-stall discards the held entry.

## Timing
- Latency: 1 cycle from accept to out_valid/out_* and branch_taken. flags_q is visible the cycle after accept.
- Throughput: 1 instruction/cycle while out_ready=1. Simultaneous drain and accept in the same cycle keeps out_valid=1 and loads the new entry.
- in_ready is combinational from out_valid and out_ready only; no combinational path from in_valid to in_ready.
- Back-to-back: instruction k with set_flags followed by B.cond at k+1 sees k's flags, because flags_q updates on k's accept edge.
- Values after reset: out_valid=0, out_result=0, out_rd=0, out_reg_write=0, branch_taken=0, flags_q=0000; in_ready=1.

## Test plan
- Reset, then idle: all outputs 0, in_ready=1. in_valid=1, alu_result=0x0000_0000_0000_002A, rd=5, reg_write=1, out_ready=1 -> next cycle out_valid=1, out_result=0x2A, out_rd=5; flags_q stays 0000 (set_flags=0).
- SUBS producing 0: set_flags=1, alu_zero=1, alu_carry_out=1 -> flags_q=0100+C=0110. Next cycle, B.cond with cond=0000 -> branch_taken=1; with cond=0001 -> 0.
- Signed compare: flags N=1, V=0 set, then B.cond cond=1011 (LT) -> taken=1; cond=1100 (GT) -> 0; cond=1110 -> 1.
- CBZ with alu_zero=1 -> taken=1. CBNZ with alu_zero=1 -> taken=0. CBZ with set_flags=0 leaves flags_q unchanged.
- Stall: out_ready=0 for 3 cycles with in_valid=1 -> outputs held and in_ready=0. A set_flags=1 presented while stalled does not change flags_q. Release out_ready -> the held entry drains and the next entry is accepted in the same cycle.
- Flush while stalled, with set_flags=1 on the incoming instruction -> out_valid=0 next cycle and flags_q unchanged. Reset asserted mid-stream -> every output returns to its reset value one cycle later.
